mlp_tile_sequencer: RTL

MLP_TILE_SEQUENCER -- requirements
Module: mlp_tile_sequencer

---
 rtl/mlp_pkg.sv | 33 +++
 rtl/mlp_requant.sv | 59 +++++
 rtl/mlp_tile_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and constants for the MLP tile sequencer.
// Holds the sequencer FSM state encoding, default parameter values and the
// requantiser intermediate widths.
package mlp_pkg;

  localparam int DEF_PE_COLS     = 8;
  localparam int DEF_MAX_K_TILES = 16;
  localparam int DEF_MAX_N_TILES = 16;
  localparam int DEF_PSUM_W      = 32;
  localparam int DEF_SCALE_W     = 12;
  localparam int DEF_OUT_W       = 8;

  // Requant shift field width
  localparam int SHIFT_W = 5;

  // Signed psum times zero-extended unsigned scale never overflows this width
  localparam int DEF_PROD_W = DEF_PSUM_W + DEF_SCALE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    BWAIT,
    ISSUE,
    WAIT,
    DRAIN,
    FIN
  } seq_state_t;

  function automatic int prod_width(input int psum_w, input int scale_w);
    return psum_w + scale_w + 1;
  endfunction

endpackage

// File: rtl/mlp_requant.sv
// mlp_requant: combinational requantiser.
// out = sat(round_shift(psum * scale, shift)).
// Optional: define MLP_SEQ_RELU_EN to clamp negative results to zero before
// saturation.
module mlp_requant
  import mlp_pkg::*;
#(
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int SCALE_W = DEF_SCALE_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic [PSUM_W-1:0]  psum,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   out
);

  localparam int PW = prod_width(PSUM_W, SCALE_W);
  // One extra bit so the rounding add cannot wrap
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] ps_ext;
  logic signed [PW-1:0] sc_ext;
  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;
  logic signed [RW-1:0] clipped;

  // Multiply, round half up, arithmetic shift, optional ReLU, then saturate
  always_comb begin
    ps_ext  = {{(PW-PSUM_W){psum[PSUM_W-1]}}, psum};
    sc_ext  = {{(PW-SCALE_W){1'b0}}, scale};
    prod    = ps_ext * sc_ext;
    rnd     = '0;
    if (shift != '0) begin
      rnd = RW'(1) << (shift - SHIFT_W'(1));
    end
    rounded = {prod[PW-1], prod} + rnd;
    shifted = rounded >>> shift;
    clipped = shifted;
`ifdef MLP_SEQ_RELU_EN
    if (shifted[RW-1]) begin
      clipped = '0;
    end
`endif
    if (clipped > SAT_MAX) begin
      out = SAT_MAX[OUT_W-1:0];
    end else if (clipped < SAT_MIN) begin
      out = SAT_MIN[OUT_W-1:0];
    end else begin
      out = clipped[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mlp_tile_sequencer.sv
// mlp_tile_sequencer: walks an MLP layer job over N output tiles, each built
// from K accumulation tiles on the PE array. For every output tile it fetches
// the bias row, issues the K array passes (feeding each partial sum back as the
// next seed), then drains the requantised row element by element.
// Optional: define MLP_SEQ_RELU_EN for ReLU-clamped requant output.
module mlp_tile_sequencer
  import mlp_pkg::*;
#(
  parameter int PE_COLS     = DEF_PE_COLS,
  parameter int MAX_K_TILES = DEF_MAX_K_TILES,
  parameter int MAX_N_TILES = DEF_MAX_N_TILES,
  parameter int PSUM_W      = DEF_PSUM_W,
  parameter int SCALE_W     = DEF_SCALE_W,
  parameter int OUT_W       = DEF_OUT_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [$clog2(MAX_K_TILES+1)-1:0]        cfg_k_tiles,
  input  logic [$clog2(MAX_N_TILES+1)-1:0]        cfg_n_tiles,
  input  logic [SCALE_W-1:0]                      cfg_scale,
  input  logic [SHIFT_W-1:0]                      cfg_shift,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    bias_rd_en,
  input  logic [PE_COLS*PSUM_W-1:0]               bias_rd_data,
  output logic                                    tile_req,
  output logic [$clog2(MAX_K_TILES)-1:0]          tile_k,
  output logic [$clog2(MAX_N_TILES)-1:0]          tile_n,
  output logic [PE_COLS*PSUM_W-1:0]               arr_bias,
  input  logic                                    arr_valid,
  input  logic [PE_COLS*PSUM_W-1:0]               arr_psum,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUT_W-1:0]                        out_data,
  output logic [$clog2(MAX_N_TILES*PE_COLS)-1:0]  out_idx
);

  localparam int KC_W = $clog2(MAX_K_TILES + 1);
  localparam int NC_W = $clog2(MAX_N_TILES + 1);
  localparam int KI_W = $clog2(MAX_K_TILES);
  localparam int NI_W = $clog2(MAX_N_TILES);
  localparam int E_W  = $clog2(PE_COLS);
  localparam int OI_W = $clog2(MAX_N_TILES * PE_COLS);

  seq_state_t state;
  seq_state_t state_next;

  logic [KI_W-1:0]    k;
  logic [NI_W-1:0]    n;
  logic [E_W-1:0]     e;
  logic [KC_W-1:0]    k_tiles;
  logic [NC_W-1:0]    n_tiles;
  logic [SCALE_W-1:0] scale_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [PSUM_W-1:0]  bank [PE_COLS];

  logic [KC_W-1:0]    k_cfg;
  logic [NC_W-1:0]    n_cfg;
  logic               k_more;
  logic               n_more;
  logic               e_last;
  logic [OUT_W-1:0]   rq_out;

  // Clamp the requested tile counts into [1, MAX]
  always_comb begin
    k_cfg = cfg_k_tiles;
    if (cfg_k_tiles == '0) begin
      k_cfg = KC_W'(1);
    end else if (cfg_k_tiles > KC_W'(MAX_K_TILES)) begin
      k_cfg = KC_W'(MAX_K_TILES);
    end
    n_cfg = cfg_n_tiles;
    if (cfg_n_tiles == '0) begin
      n_cfg = NC_W'(1);
    end else if (cfg_n_tiles > NC_W'(MAX_N_TILES)) begin
      n_cfg = NC_W'(MAX_N_TILES);
    end
  end

  // Loop-bound flags for the K, N and element counters
  always_comb begin
    k_more = (KC_W'(k) + KC_W'(1)) < k_tiles;
    n_more = (NC_W'(n) + NC_W'(1)) < n_tiles;
    e_last = (e == E_W'(PE_COLS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    bias_rd_en = 1'b0;
    tile_req   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = BIAS;
        end
      end
      BIAS: begin
        bias_rd_en = 1'b1;
        state_next = BWAIT;
      end
      BWAIT: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        tile_req   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (arr_valid) begin
          state_next = k_more ? ISSUE : DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && e_last) begin
          state_next = n_more ? BIAS : FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job configuration, tile counters, accumulator seed and psum bank
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      n        <= '0;
      e        <= '0;
      k_tiles  <= '0;
      n_tiles  <= '0;
      scale_q  <= '0;
      shift_q  <= '0;
      arr_bias <= '0;
      for (int unsigned i = 0; i < PE_COLS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_tiles <= k_cfg;
            n_tiles <= n_cfg;
            scale_q <= cfg_scale;
            shift_q <= cfg_shift;
            k       <= '0;
            n       <= '0;
            e       <= '0;
          end
        end
        BWAIT: begin
          arr_bias <= bias_rd_data;
        end
        WAIT: begin
          if (arr_valid) begin
            if (k_more) begin
              arr_bias <= arr_psum;
              k        <= k + KI_W'(1);
            end else begin
              for (int unsigned i = 0; i < PE_COLS; i++) begin
                bank[i] <= arr_psum[i*PSUM_W +: PSUM_W];
              end
              e <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (e_last) begin
              e <= '0;
              if (n_more) begin
                n <= n + NI_W'(1);
                k <= '0;
              end
            end else begin
              e <= e + E_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  mlp_requant #(
    .PSUM_W  (PSUM_W),
    .SCALE_W (SCALE_W),
    .OUT_W   (OUT_W)
  ) u_requant (
    .psum  (bank[e]),
    .scale (scale_q),
    .shift (shift_q),
    .out   (rq_out)
  );

  // Output element and index are forced to zero outside DRAIN
  always_comb begin
    tile_k   = k;
    tile_n   = n;
    out_data = '0;
    out_idx  = '0;
    if (out_valid) begin
      out_data = rq_out;
      out_idx  = OI_W'(n) * OI_W'(PE_COLS) + OI_W'(e);
    end
  end

endmodule
